// File: rtl/linear_interpolator.sv
// linear_interpolator: upsampler that accepts one unsigned sample and emits
// L = 2**LOG2_L samples stepping linearly from the previous sample toward it.
// Valid/ready handshake on both sides; outputs depend only on registered state,
// except o_ready, which also looks at i_ready so back-to-back bursts have no bubble.
module linear_interpolator #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LOG2_L = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    localparam int unsigned L     = 1 << LOG2_L;
    localparam int unsigned SUM_W = DATA_W + LOG2_L;
    localparam logic [LOG2_L-1:0] K_LAST = LOG2_L'(L - 1);

    typedef enum logic {
        StIdle,
        StEmit
    } state_t;

    state_t              r_state, w_state_d;
    logic [DATA_W-1:0]   r_prev, w_prev_d;
    logic [DATA_W-1:0]   r_cur, w_cur_d;
    logic [LOG2_L-1:0]   r_k, w_k_d;

    logic                w_k_is_last;
    logic                w_accept;
    logic                w_xfer;
    logic [LOG2_L:0]     w_weight_prev;
    logic [SUM_W-1:0]    w_sum;
    logic [DATA_W-1:0]   w_interp;

    // Weighted sum prev*(L-k) + cur*k; SUM_W bits hold the worst case (max * L).
    always_comb begin
        w_k_is_last   = (r_k == K_LAST);
        w_weight_prev = (LOG2_L + 1)'(L) - {1'b0, r_k};
        w_sum         = (SUM_W'(r_prev) * SUM_W'(w_weight_prev))
                      + (SUM_W'(r_cur) * SUM_W'(r_k));
        // Dropping the low LOG2_L bits is a floor divide by L.
        w_interp      = w_sum[SUM_W-1:LOG2_L];
    end

    // Handshake and output decode; o_data is forced to zero while idle.
    always_comb begin
        o_valid  = (r_state == StEmit);
        o_last   = o_valid && w_k_is_last;
        o_data   = o_valid ? w_interp : '0;
        o_ready  = (r_state == StIdle) || (o_valid && w_k_is_last && i_ready);
        w_accept = i_valid && o_ready;
        w_xfer   = o_valid && i_ready;
    end

    // Next-state logic for the FSM, phase counter and sample registers.
    always_comb begin
        w_state_d = r_state;
        w_prev_d  = r_prev;
        w_cur_d   = r_cur;
        w_k_d     = r_k;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_cur_d   = i_data;
                    w_k_d     = '0;
                    w_state_d = StEmit;
                end
            end
            StEmit: begin
                if (w_xfer) begin
                    if (!w_k_is_last) begin
                        w_k_d = r_k + 1'b1;
                    end else begin
                        w_prev_d = r_cur;
                        w_k_d    = '0;
                        if (w_accept) begin
                            // Chain straight into the next burst.
                            w_cur_d = i_data;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_prev  <= '0;
            r_cur   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_d;
            r_prev  <= w_prev_d;
            r_cur   <= w_cur_d;
            r_k     <= w_k_d;
        end
    end

    // Guards $past-based checks on the first clock after reset.
    logic r_past_valid;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_past_valid <= 1'b0;
        end else begin
            r_past_valid <= 1'b1;
        end
    end

    logic [DATA_W-1:0] w_lo, w_hi;

    // Bounds of the interpolation segment.
    always_comb begin
        w_lo = (r_prev < r_cur) ? r_prev : r_cur;
        w_hi = (r_prev < r_cur) ? r_cur : r_prev;
    end

    a_valid_state : assert property (@(posedge i_clk) disable iff (i_reset)
        o_valid == (r_state == StEmit));

    a_data_range : assert property (@(posedge i_clk) disable iff (i_reset)
        o_valid |-> (o_data >= w_lo && o_data <= w_hi));

    a_backpressure_stable : assert property (@(posedge i_clk) disable iff (i_reset)
        (r_past_valid && $past(o_valid && !i_ready)) |->
        (o_valid && $stable(o_data) && $stable(o_last) && $stable(r_k)
         && $stable(r_prev) && $stable(r_cur)));

endmodule

// File: tb/tb_linear_interpolator.sv
// Directed bench for linear_interpolator (DATA_W=8, L=4); expected values are
// hand-computed from prev*(L-k)+cur*k >> 2.
module tb_linear_interpolator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int n_checks = 0;
    int n_fail   = 0;

    linear_interpolator #(
        .DATA_W(8),
        .LOG2_L(2)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (in_data),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (out_data),
        .o_last  (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input string tag, input int data, input bit last);
        #1;
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " data"}, 32'(out_data), 32'(data));
        chk({tag, " last"}, 32'(out_last), 32'(last));
    endtask

    task automatic idle_check(input string tag);
        #1;
        chk({tag, " valid"}, 32'(out_valid), 32'd0);
        chk({tag, " ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset data", 32'(out_data), 32'd0);
        chk("reset last", 32'(out_last), 32'd0);
        chk("reset ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Burst 1: 0 -> 100.
        in_valid = 1'b1;
        in_data  = 8'd100;
        #1 chk("b1 accept ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'd0;
        beat("b1 k0", 0, 1'b0);
        tick();
        beat("b1 k1", 25, 1'b0);
        tick();
        beat("b1 k2", 50, 1'b0);
        tick();
        beat("b1 k3", 75, 1'b1);
        // Offer 200 on the last beat: accepted with no bubble.
        in_valid = 1'b1;
        in_data  = 8'd200;
        #1 chk("b1 k3 ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'd0;
        beat("b2 k0", 100, 1'b0);
        tick();
        beat("b2 k1", 125, 1'b0);

        // Backpressure for three cycles; offered input must be refused.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd77;
        #1 chk("bp ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            beat("bp hold", 125, 1'b0);
            chk("bp hold ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        tick();
        beat("b2 k2", 150, 1'b0);
        tick();
        beat("b2 k3", 175, 1'b1);
        #1 chk("b2 k3 ready", 32'(in_ready), 32'd1);
        tick();
        idle_check("after b2");
        chk("idle data", 32'(out_data), 32'd0);

        // Decreasing step 200 -> 0, then reset before the last beat transfers.
        in_valid = 1'b1;
        in_data  = 8'd0;
        tick();
        in_valid = 1'b0;
        beat("dec k0", 200, 1'b0);
        tick();
        beat("dec k1", 150, 1'b0);
        tick();
        beat("dec k2", 100, 1'b0);
        tick();
        beat("dec k3", 50, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("async rst valid", 32'(out_valid), 32'd0);
        chk("async rst data", 32'(out_data), 32'd0);
        chk("async rst last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // After reset the burst starts from 0.
        in_valid = 1'b1;
        in_data  = 8'd40;
        tick();
        in_valid = 1'b0;
        in_data  = 8'd0;
        beat("r40 k0", 0, 1'b0);
        tick();
        beat("r40 k1", 10, 1'b0);
        tick();
        beat("r40 k2", 20, 1'b0);
        tick();
        beat("r40 k3", 30, 1'b1);
        tick();
        idle_check("after r40");

        // Reset while idle, then full-scale step with floor truncation.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd255;
        tick();
        in_valid = 1'b0;
        in_data  = 8'd0;
        beat("fs k0", 0, 1'b0);
        tick();
        beat("fs k1", 63, 1'b0);
        tick();
        beat("fs k2", 127, 1'b0);
        tick();
        beat("fs k3", 191, 1'b1);
        tick();
        idle_check("after fs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
